// File: rtl/player_link_pkg.sv
// Shared types and field constants for the player-word UART link.
// Frame state encoding plus the bit layout of the encoded player word.
package player_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int RST_BIT   = 7;
    localparam int RSVD_BIT  = 6;
    localparam int FIRE_BIT  = 5;
    localparam int PROJ_BIT  = 4;
    localparam int LANE_MSB  = 3;
    localparam int LANE_LSB  = 0;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/player_uart_tx_if.sv
// Player-word link between the player controller (master) and the
// UART transmitter (slave), which drives the serial pin and status.
interface player_uart_tx_if;

    logic [7:0] data_in;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [7:0] last_sent;

    modport master (
        output data_in,
        input  tx,
        input  busy,
        input  frame_done,
        input  last_sent
    );

    modport slave (
        input  data_in,
        output tx,
        output busy,
        output frame_done,
        output last_sent
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and pulses tick on the
// terminal count; held at zero while clear is high.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == TERM);
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/player_uart_tx.sv
// UART transmitter for the encoded player word: sends on change, on a
// periodic refresh, and once after reset. UART_TX_PARITY_EN adds even parity.
module player_uart_tx
    import player_link_pkg::*;
#(
    parameter int CLK_FREQ       = 100000000,
    parameter int BAUD_RATE      = 9600,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    player_uart_tx_if.slave  link
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam bit REF_EN = (REFRESH_CYCLES > 0);
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REF_TERM =
        RW'(REF_EN ? REFRESH_CYCLES - 1 : 0);

    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  last_q, last_d;
    logic        first_q, first_d;
    logic        refp_q, refp_d;
    logic [RW-1:0] refcnt_q, refcnt_d;
    logic        tx_q, tx_d;
    logic        par_q, par_d;
    logic        tick;
    logic        ref_hit;
    logic        trigger;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        last_d   = last_q;
        first_d  = first_q;
        refp_d   = refp_q;
        refcnt_d = refcnt_q;
        par_d    = par_q;
        tx_d     = 1'b1;
        ref_hit  = REF_EN && (state_q == IDLE) && (refcnt_q == REF_TERM);
        trigger  = first_q || (link.data_in != last_q) || refp_q || ref_hit;

        unique case (state_q)
            IDLE: begin
                // Refresh expiry starts the frame in the same cycle, so the
                // terminal-count wrap happens through the frame-start clear.
                if (trigger) begin
                    shift_d  = link.data_in;
                    last_d   = link.data_in;
                    par_d    = even_parity(link.data_in);
                    first_d  = 1'b0;
                    refp_d   = 1'b0;
                    refcnt_d = '0;
                    state_d  = START;
                end else if (REF_EN) begin
                    refcnt_d = refcnt_q + RW'(1);
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level is registered from the next state to keep the pin clean.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            last_q   <= '0;
            first_q  <= 1'b1;
            refp_q   <= 1'b0;
            refcnt_q <= '0;
            tx_q     <= 1'b1;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            first_q  <= first_d;
            refp_q   <= refp_d;
            refcnt_q <= refcnt_d;
            tx_q     <= tx_d;
            par_q    <= par_d;
        end
    end

    assign link.tx         = tx_q;
    assign link.busy       = (state_q != IDLE);
    assign link.frame_done = (state_q == STOP) && tick;
    assign link.last_sent  = last_q;

endmodule

// File: tb/tb_player_uart_tx.sv
// Bench for player_uart_tx: a line monitor decodes frames and checks
// them against expected words queued by the scenario tasks.
module tb_player_uart_tx;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * CPB;
    localparam int REF = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int ncyc = 0;
    int nfr = 0;
    logic [7:0] exp_q[$];
    int st[$];

    player_uart_tx_if link();

    player_uart_tx #(
        .CLK_FREQ(1000),
        .BAUD_RATE(100),
        .REFRESH_CYCLES(REF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .link(link)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    initial begin
        bit act;
        int mc;
        int k;
        logic [7:0] sh;
        logic [7:0] e;
        act = 0;
        mc = 0;
        sh = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 0;
            end else if (!act) begin
                if (link.tx === 1'b0) begin
                    act = 1;
                    mc = 0;
                    st.push_back(ncyc);
                end
            end else begin
                mc++;
            end
            if (act) begin
                if (mc == 4) begin
                    vectors++;
                    if (link.tx !== 1'b0) begin
                        miscompares++;
                        $display("FAIL start_bit got %b want 0", link.tx);
                    end
                end
                if (mc >= 14 && mc <= 84 && mc % 10 == 4) begin
                    k = (mc - 14) / 10;
                    sh[k[2:0]] = link.tx;
                end
`ifdef UART_TX_PARITY_EN
                if (mc == 94) begin
                    vectors++;
                    if (link.tx !== ^sh) begin
                        miscompares++;
                        $display("FAIL parity_bit got %b want %b", link.tx, ^sh);
                    end
                end
`endif
                if (mc == FL - 6) begin
                    vectors++;
                    if (link.tx !== 1'b1) begin
                        miscompares++;
                        $display("FAIL stop_bit got %b want 1", link.tx);
                    end
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_frame got %h want none", sh);
                    end else begin
                        e = exp_q.pop_front();
                        if (sh !== e) begin
                            miscompares++;
                            $display("FAIL frame_data got %h want %h", sh, e);
                        end
                    end
                    nfr++;
                end
                if (mc == FL - 2) begin
                    vectors++;
                    if (link.frame_done !== 1'b0) begin
                        miscompares++;
                        $display("FAIL frame_done_early got %b want 0", link.frame_done);
                    end
                end
                if (mc == FL - 1) begin
                    vectors++;
                    if (link.frame_done !== 1'b1) begin
                        miscompares++;
                        $display("FAIL frame_done_last got %b want 1", link.frame_done);
                    end
                    act = 0;
                end
            end
        end
    end

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while (nfr < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        vectors++;
        if (nfr < n) begin
            miscompares++;
            $display("FAIL wait_frames got %0d want %0d", nfr, n);
        end
    endtask

    task automatic wait_start(input int n, input int budget);
        int c = 0;
        while (st.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        vectors++;
        if (st.size() < n) begin
            miscompares++;
            $display("FAIL wait_start got %0d want %0d", st.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (link.busy !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
    endtask

    function automatic int gap(input int i);
        if (st.size() > i) return st[i] - st[i-1];
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        link.data_in = 8'h05;
        repeat (3) @(negedge clk);
        vectors += 4;
        if (link.tx !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_tx got %b want 1", link.tx);
        end
        if (link.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 0", link.busy);
        end
        if (link.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done got %b want 0", link.frame_done);
        end
        if (link.last_sent !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_last got %h want 00", link.last_sent);
        end
        rst = 1'b0;
        exp_q.push_back(8'h05);
        @(negedge clk);
        vectors += 3;
        if (link.tx !== 1'b0) begin
            miscompares++;
            $display("FAIL first_start_tx got %b want 0", link.tx);
        end
        if (link.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL first_busy got %b want 1", link.busy);
        end
        if (link.last_sent !== 8'h05) begin
            miscompares++;
            $display("FAIL first_last got %h want 05", link.last_sent);
        end
        wait_frames(1, FL + 20);
        wait_idle(20);
        vectors++;
        if (link.busy !== 1'b0 || link.tx !== 1'b1) begin
            miscompares++;
            $display("FAIL post_frame_idle got busy=%b tx=%b want 0 1",
                     link.busy, link.tx);
        end
    endtask

    task automatic test_refresh();
        exp_q.push_back(8'h05);
        wait_frames(2, FL + REF + 120);
        vectors++;
        if (gap(1) !== FL + REF) begin
            miscompares++;
            $display("FAIL refresh_gap got %0d want %0d", gap(1), FL + REF);
        end
    endtask

    task automatic test_coalesce();
        exp_q.push_back(8'h05);
        wait_start(3, FL + REF + 120);
        repeat (15) @(negedge clk);
        link.data_in = 8'h06;
        repeat (20) @(negedge clk);
        link.data_in = 8'h25;
        exp_q.push_back(8'h25);
        wait_frames(4, 2 * FL + 50);
        vectors += 2;
        if (gap(3) !== FL + 1) begin
            miscompares++;
            $display("FAIL b2b_gap got %0d want %0d", gap(3), FL + 1);
        end
        if (link.last_sent !== 8'h25) begin
            miscompares++;
            $display("FAIL coalesce_last got %h want 25", link.last_sent);
        end
    endtask

    task automatic test_mid_reset();
        link.data_in = 8'h3C;
        wait_start(5, FL + 50);
        repeat (43) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors += 3;
        if (link.tx !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_tx got %b want 1", link.tx);
        end
        if (link.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_busy got %b want 0", link.busy);
        end
        if (link.last_sent !== 8'h00) begin
            miscompares++;
            $display("FAIL midrst_last got %h want 00", link.last_sent);
        end
        link.data_in = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(8'h00);
        @(negedge clk);
        vectors++;
        if (link.tx !== 1'b0) begin
            miscompares++;
            $display("FAIL first_pending_tx got %b want 0", link.tx);
        end
        wait_frames(5, FL + 20);
    endtask

    task automatic test_simul();
        int target;
        int c = 0;
        target = (st.size() > 5) ? st[5] + FL + REF - 1 : ncyc;
        while (ncyc < target && c < 400) begin
            @(negedge clk);
            c++;
        end
        link.data_in = 8'h5A;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        wait_frames(7, 2 * (FL + REF) + 50);
        vectors += 2;
        if (gap(6) !== FL + REF) begin
            miscompares++;
            $display("FAIL simul_gap got %0d want %0d", gap(6), FL + REF);
        end
        if (gap(7) !== FL + REF) begin
            miscompares++;
            $display("FAIL refresh_restart got %0d want %0d", gap(7), FL + REF);
        end
    endtask

    task automatic test_back_to_back();
        wait_idle(40);
        link.data_in = 8'h07;
        exp_q.push_back(8'h07);
        wait_start(9, 20);
        repeat (30) @(negedge clk);
        link.data_in = 8'h80;
        exp_q.push_back(8'h80);
        wait_frames(9, 2 * FL + 50);
        vectors += 2;
        if (gap(9) !== FL + 1) begin
            miscompares++;
            $display("FAIL b2b_gap2 got %0d want %0d", gap(9), FL + 1);
        end
        if (link.last_sent !== 8'h80) begin
            miscompares++;
            $display("FAIL b2b_last got %h want 80", link.last_sent);
        end
        wait_idle(20);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expected got %0d want 0", exp_q.size());
        end
    endtask

    initial begin
        link.data_in = 8'h05;
        test_reset();
        test_refresh();
        test_coalesce();
        test_mid_reset();
        test_simul();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
